inst_queue: RTL and testbench

//  Parametrised fetch-to-decode instruction buffer; successor to the fixed two-slot a/b hand-off into the ID stage.

---
 rtl/inst_queue.sv | 124 ++++++++++++
 tb/tb_inst_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction buffer: circular queue taking up to FETCH_W packets per cycle and presenting the ISSUE_W oldest.
// Optional same-cycle bypass when empty is enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned EXC_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [$clog2(FETCH_W+1)-1:0] in_count,
  input  logic [FETCH_W*32-1:0]       in_pc,
  input  logic [FETCH_W*32-1:0]       in_inst,
  input  logic [FETCH_W-1:0]          in_pred_branch_taken,
  input  logic [FETCH_W*32-1:0]       in_pred_branch_target,
  input  logic [FETCH_W-1:0]          in_have_exception,
  input  logic [FETCH_W*EXC_W-1:0]    in_exception_type,
  output logic                        in_ready,
  output logic [ISSUE_W-1:0]          out_valid,
  output logic [ISSUE_W*32-1:0]       out_pc,
  output logic [ISSUE_W*32-1:0]       out_inst,
  output logic [ISSUE_W-1:0]          out_pred_branch_taken,
  output logic [ISSUE_W*32-1:0]       out_pred_branch_target,
  output logic [ISSUE_W-1:0]          out_have_exception,
  output logic [ISSUE_W*EXC_W-1:0]    out_exception_type,
  input  logic [$clog2(ISSUE_W+1)-1:0] consume
);

  localparam int unsigned CW    = $clog2(FETCH_W+1);
  localparam int unsigned IW    = $clog2(ISSUE_W+1);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned NW    = $clog2(DEPTH+1);
  localparam int unsigned ENT_W = 32 + 32 + 1 + 32 + 1 + EXC_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [NW-1:0]    count;

  logic [ENT_W-1:0] in_ent  [FETCH_W];
  logic [ENT_W-1:0] out_ent [ISSUE_W];
  logic             byp;
  logic [NW-1:0]    acc;
  logic [NW-1:0]    avail;
  logic [NW-1:0]    taken;
  logic [NW-1:0]    skip;
  logic [NW-1:0]    enq;
  logic [NW-1:0]    deq;

  // Accept/issue accounting; in bypass the consumed lanes come straight from the fetch packet.
  always_comb begin
    in_ready = (NW'(DEPTH) - count) >= NW'(FETCH_W);
    acc      = in_ready ? NW'(in_count) : '0;
    byp      = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp      = (count == '0) && !flush && (acc != '0);
`endif
    if (byp) avail = (acc < NW'(ISSUE_W)) ? acc : NW'(ISSUE_W);
    else     avail = (count < NW'(ISSUE_W)) ? count : NW'(ISSUE_W);
    taken = (NW'(consume) < avail) ? NW'(consume) : avail;
    skip  = byp ? taken : '0;
    deq   = byp ? '0 : taken;
    enq   = acc - skip;
  end

  // Pack fetch lanes and unpack the issue window.
  always_comb begin
    for (int i = 0; i < int'(FETCH_W); i++) begin
      in_ent[i] = {in_pc[32*i+:32], in_inst[32*i+:32], in_pred_branch_taken[i],
                   in_pred_branch_target[32*i+:32], in_have_exception[i],
                   in_exception_type[EXC_W*i+:EXC_W]};
    end
    out_valid              = '0;
    out_pc                 = '0;
    out_inst               = '0;
    out_pred_branch_taken  = '0;
    out_pred_branch_target = '0;
    out_have_exception     = '0;
    out_exception_type     = '0;
    for (int i = 0; i < int'(ISSUE_W); i++) begin
      out_ent[i]   = byp ? in_ent[i % int'(FETCH_W)] : mem[head + PW'(i)];
      out_valid[i] = avail > NW'(i);
      {out_pc[32*i+:32], out_inst[32*i+:32], out_pred_branch_taken[i],
       out_pred_branch_target[32*i+:32], out_have_exception[i],
       out_exception_type[EXC_W*i+:EXC_W]} = out_ent[i];
    end
  end

  // Storage is not reset; only lanes not bypassed this cycle are written.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int j = 0; j < int'(FETCH_W); j++) begin
        if (NW'(j) < enq) mem[tail + PW'(j)] <= in_ent[(j + int'(skip)) % int'(FETCH_W)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(enq);
      count <= count + enq - deq;
    end
  end

  // Protocol checks: oversize fetch packet is an error, over-consume is clamped and flagged.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (in_count <= CW'(FETCH_W))
        else $error("inst_queue: in_count %0d exceeds FETCH_W", in_count);
      assert (NW'(consume) <= avail)
        else $warning("inst_queue: consume %0d exceeds %0d valid lanes, clamped", consume, avail);
    end
  end

  logic unused_iw;
  assign unused_iw = ^IW'(0);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=8, FETCH_W=2, ISSUE_W=2); define INST_QUEUE_BYPASS_EN to add the bypass case.
module tb_inst_queue;

  localparam int unsigned EXC_W = 8;
  localparam logic [31:0] BASE  = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  in_count;
  logic [63:0] in_pc;
  logic [63:0] in_inst;
  logic [1:0]  in_pred_branch_taken;
  logic [63:0] in_pred_branch_target;
  logic [1:0]  in_have_exception;
  logic [15:0] in_exception_type;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_pred_branch_taken;
  logic [63:0] out_pred_branch_target;
  logic [1:0]  out_have_exception;
  logic [15:0] out_exception_type;
  logic [1:0]  consume;

  int checks   = 0;
  int failures = 0;

  inst_queue #(.DEPTH(8), .FETCH_W(2), .ISSUE_W(2), .EXC_W(EXC_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_count(in_count),
    .in_pc(in_pc), .in_inst(in_inst), .in_pred_branch_taken(in_pred_branch_taken),
    .in_pred_branch_target(in_pred_branch_target), .in_have_exception(in_have_exception),
    .in_exception_type(in_exception_type), .in_ready(in_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_pred_branch_taken(out_pred_branch_taken),
    .out_pred_branch_target(out_pred_branch_target), .out_have_exception(out_have_exception),
    .out_exception_type(out_exception_type), .consume(consume)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a fetch packet of n lanes starting at pc0, plus a consume count.
  task automatic drive(input int n, input logic [31:0] pc0, input int c);
    in_count              = 2'(n);
    in_pc                 = {pc0 + 32'd4, pc0};
    in_inst               = {(pc0 + 32'd4) ^ 32'hA5A5_0000, pc0 ^ 32'hA5A5_0000};
    in_pred_branch_taken  = 2'b10;
    in_pred_branch_target = {pc0 + 32'h104, pc0 + 32'h100};
    in_have_exception     = 2'b00;
    in_exception_type     = '0;
    consume               = 2'(c);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(0, 32'h0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);

    // First packet: latency and lane ordering.
    drive(2, BASE, 0);
`ifdef INST_QUEUE_BYPASS_EN
    check("t1_same_cycle_valid", 32'(out_valid), 32'h3);
`else
    check("t1_same_cycle_valid", 32'(out_valid), 32'h0);
`endif
    tick();
    drive(0, 32'h0, 0);
    check("t1_valid", 32'(out_valid), 32'h3);
    check("t1_pc0", out_pc[31:0], BASE);
    check("t1_pc1", out_pc[63:32], BASE + 32'd4);
    check("t1_inst0", out_inst[31:0], BASE ^ 32'hA5A5_0000);
    check("t1_tgt1", out_pred_branch_target[63:32], BASE + 32'h104);
    check("t1_taken", 32'(out_pred_branch_taken), 32'h2);

    // Fill to DEPTH, then a blocked packet.
    for (int k = 1; k < 4; k++) begin
      drive(2, BASE + 32'(8 * k), 0);
      tick();
      drive(0, 32'h0, 0);
      check($sformatf("t2_ready_%0d", k), 32'(in_ready), (k == 3) ? 32'h0 : 32'h1);
    end
    drive(2, BASE + 32'h20, 0);
    check("t2_full_ready", 32'(in_ready), 32'h0);
    tick();
    drive(0, 32'h0, 0);
    check("t2_full_pc0", out_pc[31:0], BASE);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_drain_pc0_%0d", k), out_pc[31:0], BASE + 32'(8 * k));
      check($sformatf("t2_drain_pc1_%0d", k), out_pc[63:32], BASE + 32'(8 * k + 4));
      drive(0, 32'h0, 2);
      tick();
      drive(0, 32'h0, 0);
      check($sformatf("t2_drain_ready_%0d", k), 32'(in_ready), 32'h1);
    end
    check("t2_empty_valid", 32'(out_valid), 32'h0);

    // Steady stream across several pointer wraps.
    drive(2, BASE, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(2, BASE + 32'(8 * (k + 1)), 2);
      check($sformatf("t3_valid_%0d", k), 32'(out_valid), 32'h3);
      check($sformatf("t3_pc0_%0d", k), out_pc[31:0], BASE + 32'(8 * k));
      check($sformatf("t3_pc1_%0d", k), out_pc[63:32], BASE + 32'(8 * k + 4));
      tick();
    end
    drive(0, 32'h0, 2);
    tick();
    drive(0, 32'h0, 0);
    check("t3_end_valid", 32'(out_valid), 32'h0);

    // Flush at count=5 with a concurrent enqueue and consume.
    for (int k = 0; k < 3; k++) begin
      drive(2, BASE + 32'(8 * k), 0);
      tick();
    end
    drive(0, 32'h0, 1);
    tick();
    drive(0, 32'h0, 0);
    check("t4_pre_ready", 32'(in_ready), 32'h1);
    check("t4_pre_pc0", out_pc[31:0], BASE + 32'd4);
    flush = 1'b1;
    drive(2, BASE + 32'h40, 1);
    tick();
    flush = 1'b0;
    drive(0, 32'h0, 0);
    check("t4_valid", 32'(out_valid), 32'h0);
    check("t4_ready", 32'(in_ready), 32'h1);
    tick();
    check("t4_valid_hold", 32'(out_valid), 32'h0);

    // Exception bits pass through; over-consume drains just the one entry.
    drive(1, BASE + 32'h80, 0);
    in_have_exception     = 2'b01;
    in_exception_type     = {8'h00, 8'h2d};
    in_pred_branch_taken  = 2'b01;
    tick();
    drive(0, 32'h0, 2);
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_pc0", out_pc[31:0], BASE + 32'h80);
    check("t5_exc", 32'(out_have_exception[0]), 32'h1);
    check("t5_exc_type", 32'(out_exception_type[7:0]), 32'h2d);
    check("t5_taken", 32'(out_pred_branch_taken[0]), 32'h1);
    tick();
    drive(0, 32'h0, 0);
    check("t5_valid_after", 32'(out_valid), 32'h0);
    check("t5_ready_after", 32'(in_ready), 32'h1);

`ifdef INST_QUEUE_BYPASS_EN
    // Bypass: lane0 consumed in the same cycle, lane1 retained.
    drive(2, BASE + 32'h100, 1);
    check("t6_byp_valid", 32'(out_valid), 32'h3);
    check("t6_byp_pc0", out_pc[31:0], BASE + 32'h100);
    check("t6_byp_pc1", out_pc[63:32], BASE + 32'h104);
    tick();
    drive(0, 32'h0, 0);
    check("t6_valid", 32'(out_valid), 32'h1);
    check("t6_pc0", out_pc[31:0], BASE + 32'h104);
    check("t6_inst0", out_inst[31:0], (BASE + 32'h104) ^ 32'hA5A5_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
